// File: rtl/mem_access_unit.sv
// Load/store access unit: turns one core access into a req/gnt + rvalid bus transaction,
// steering byte/halfword lanes for stores and extending load data back to the core.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [2:0]  core_funct3,
    output logic [31:0] core_rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RD,
        S_DONE,
        S_ERR
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [1:0]         off_q, off_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [3:0]         mem_wstrb_q, mem_wstrb_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [31:0]        core_rdata_q, core_rdata_d;

    logic               access_ok;
    logic [3:0]         store_strb;
    logic [31:0]        store_data;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [31:0]        load_ext;

    // Width/alignment legality of the incoming request
    always_comb begin
        access_ok = 1'b0;
        case (core_funct3)
            3'd0:    access_ok = 1'b1;
            3'd1:    access_ok = ~core_addr[0];
            3'd2:    access_ok = (core_addr[1:0] == 2'b00);
            3'd4:    access_ok = ~core_we;
            3'd5:    access_ok = ~core_we & ~core_addr[0];
            default: access_ok = 1'b0;
        endcase
    end

    always_comb begin
        store_strb = 4'b1111;
        store_data = core_wdata;
        case (core_funct3[1:0])
            2'd0: begin
                store_strb = 4'b0001 << core_addr[1:0];
                store_data = {4{core_wdata[7:0]}};
            end
            2'd1: begin
                store_strb = 4'b0011 << {core_addr[1], 1'b0};
                store_data = {2{core_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane select and sign/zero extension from the latched width and offset
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q[1:0])
            2'd0:    load_ext = funct3_q[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'd1:    load_ext = funct3_q[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_wdata_d  = mem_wdata_q;
        core_rdata_d = core_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (core_req) begin
                    funct3_d = core_funct3;
                    off_d    = core_addr[1:0];
                    if (!access_ok) begin
                        state_d = S_ERR;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = S_REQ;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = core_we;
                        mem_addr_d  = {core_addr[31:2], 2'b00};
                        mem_wstrb_d = core_we ? store_strb : 4'b0000;
                        mem_wdata_d = store_data;
                    end
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    if (mem_we_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_WAIT_RD;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_ERR;
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_RD: begin
                if (mem_rvalid) begin
                    state_d      = S_DONE;
                    core_rdata_d = load_ext;
                    done_d       = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wstrb_q  <= 4'h0;
            mem_wdata_q  <= 32'h0;
            core_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_wdata_q  <= mem_wdata_d;
            core_rdata_q <= core_rdata_d;
        end
    end

    assign core_rdata = core_rdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_wdata  = mem_wdata_q;

endmodule
